// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller: hit/miss resolution, dirty-victim writeback,
// word-serial line refill over a ready handshake, and hit/miss event counters.
`timescale 1ns/1ps
module dcache_ctrl #(
  parameter int WORDS = 4,
  parameter int LINES = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Addr,
  input  logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  Stall,
  input  logic [LINES-1:0]      BlkValid,
  input  logic [LINES-1:0]      BlkDirty,
  input  logic [26*LINES-1:0]   BlkTag,
  input  logic [32*LINES-1:0]   BlkRD,
  output logic [LINES-1:0]      BlkWE,
  output logic [1:0]            BlkOffset,
  output logic                  BlkSetValid,
  output logic                  BlkSetDirty,
  output logic [25:0]           BlkSetTag,
  output logic [31:0]           BlkWD,
  output logic                  MReq,
  output logic                  MWE,
  output logic [31:0]           MAddr,
  output logic [31:0]           MWD,
  input  logic [31:0]           MRD,
  input  logic                  MReady,
  output logic [31:0]           HitCount,
  output logic [31:0]           MissCount
);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  localparam logic [1:0] LAST_BEAT = 2'(WORDS - 1);

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [31:0] miss_addr_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  logic        req;
  logic [1:0]  idx;
  logic [25:0] tag_sel;
  logic [31:0] rd_sel;
  logic        valid_sel;
  logic        dirty_sel;
  logic        hit;
  logic        last_beat;

  assign req       = MemRead | MemWrite;
  // During a miss the index comes from the captured address, not the live bus.
  assign idx       = (state_q == IDLE) ? Addr[5:4] : miss_addr_q[5:4];
  assign valid_sel = BlkValid[idx];
  assign dirty_sel = BlkDirty[idx];
  assign hit       = (state_q == IDLE) & req & valid_sel & (tag_sel == Addr[31:6]);
  assign last_beat = MReady & (cnt_q == LAST_BEAT);

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    tag_sel = '0;
    rd_sel  = '0;
    for (int i = 0; i < LINES; i++) begin
      if (idx == 2'(i)) begin
        tag_sel = BlkTag[26*i +: 26];
        rd_sel  = BlkRD[32*i +: 32];
      end
    end
  end

  always_comb begin
    Stall       = 1'b0;
    BlkWE       = '0;
    BlkOffset   = Addr[3:2];
    BlkSetValid = 1'b0;
    BlkSetDirty = 1'b0;
    BlkSetTag   = Addr[31:6];
    BlkWD       = WriteData;
    MReq        = 1'b0;
    MWE         = 1'b0;
    MAddr       = '0;
    MWD         = '0;
    unique case (state_q)
      IDLE: begin
        Stall = req & ~hit;
        if (hit && MemWrite) begin
          BlkWE[idx]  = 1'b1;
          BlkSetValid = 1'b1;
          BlkSetDirty = 1'b1;
        end
      end
      WB: begin
        Stall     = 1'b1;
        MReq      = 1'b1;
        MWE       = 1'b1;
        BlkOffset = cnt_q;
        MAddr     = {tag_sel, idx, cnt_q, 2'b00};
        MWD       = rd_sel;
      end
      FILL: begin
        Stall       = 1'b1;
        MReq        = 1'b1;
        BlkOffset   = cnt_q;
        MAddr       = {miss_addr_q[31:6], idx, cnt_q, 2'b00};
        BlkWD       = MRD;
        BlkSetTag   = miss_addr_q[31:6];
        // The line only becomes valid with its final word.
        BlkSetValid = (cnt_q == LAST_BEAT);
        BlkWE[idx]  = MReady;
      end
      default: ;
    endcase
  end

  assign ReadData  = rd_sel;
  assign HitCount  = hit_cnt_q;
  assign MissCount = miss_cnt_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
          end else if (req) begin
            miss_addr_q <= Addr;
            miss_cnt_q  <= miss_cnt_q + 32'd1;
            cnt_q       <= '0;
            state_q     <= (valid_sel & dirty_sel) ? WB : FILL;
          end
        end
        WB: begin
          if (MReady) cnt_q <= cnt_q + 2'd1;
          if (last_beat) begin
            cnt_q   <= '0;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (MReady) cnt_q <= cnt_q + 2'd1;
          if (last_beat) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], miss_addr_q[3:0]};

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural model of the four line blocks,
// a vector table for IDLE-state hits, and hand sequences for miss/refill/reset.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  logic         CLK = 1'b0;
  logic         Reset;
  logic         MemRead, MemWrite;
  logic [31:0]  Addr, WriteData, ReadData;
  logic         Stall;
  logic [3:0]   BlkValid, BlkDirty, BlkWE;
  logic [103:0] BlkTag;
  logic [127:0] BlkRD;
  logic [1:0]   BlkOffset;
  logic         BlkSetValid, BlkSetDirty;
  logic [25:0]  BlkSetTag;
  logic [31:0]  BlkWD;
  logic         MReq, MWE;
  logic [31:0]  MAddr, MWD, MRD;
  logic         MReady;
  logic [31:0]  HitCount, MissCount;

  int total = 0;
  int bad   = 0;

  dcache_ctrl #(.WORDS(4), .LINES(4)) dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .BlkValid(BlkValid), .BlkDirty(BlkDirty), .BlkTag(BlkTag), .BlkRD(BlkRD),
    .BlkWE(BlkWE), .BlkOffset(BlkOffset), .BlkSetValid(BlkSetValid),
    .BlkSetDirty(BlkSetDirty), .BlkSetTag(BlkSetTag), .BlkWD(BlkWD),
    .MReq(MReq), .MWE(MWE), .MAddr(MAddr), .MWD(MWD), .MRD(MRD),
    .MReady(MReady), .HitCount(HitCount), .MissCount(MissCount)
  );

  always #5 CLK = ~CLK;

  // Behavioural model of the four single-line blocks.
  logic [31:0] m_data [4][4];
  logic [25:0] m_tag  [4];
  logic [3:0]  m_valid, m_dirty;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_valid <= '0;
      m_dirty <= '0;
      for (int i = 0; i < 4; i++) m_tag[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (BlkWE[i]) begin
          m_data[i][BlkOffset] <= BlkWD;
          m_valid[i]           <= BlkSetValid;
          m_dirty[i]           <= BlkSetDirty;
          m_tag[i]             <= BlkSetTag;
        end
      end
    end
  end

  always_comb begin
    BlkValid = m_valid;
    BlkDirty = m_dirty;
    BlkTag   = '0;
    BlkRD    = '0;
    for (int i = 0; i < 4; i++) begin
      BlkTag[26*i +: 26] = m_tag[i];
      BlkRD[32*i +: 32]  = m_data[i][BlkOffset];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serve nbeats memory beats, gap idle cycles before each MReady pulse.
  task automatic mem_phase(input string tag, input logic we, input logic [31:0] base,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input int gap, input int nbeats);
    logic [31:0] d [4];
    d = '{d0, d1, d2, d3};
    for (int k = 0; k < nbeats; k++) begin
      repeat (gap) begin
        MReady = 1'b0;
        @(negedge CLK);
        #1;
        check($sformatf("%s gap%0d mreq", tag, k), {31'd0, MReq}, 32'd1);
      end
      #1;
      check($sformatf("%s b%0d stall", tag, k), {31'd0, Stall}, 32'd1);
      check($sformatf("%s b%0d mreq", tag, k), {31'd0, MReq}, 32'd1);
      check($sformatf("%s b%0d mwe", tag, k), {31'd0, MWE}, {31'd0, we});
      check($sformatf("%s b%0d maddr", tag, k), MAddr, base + 32'(4 * k));
      if (we) check($sformatf("%s b%0d mwd", tag, k), MWD, d[k]);
      MReady = 1'b1;
      MRD    = we ? 32'h0 : d[k];
      @(negedge CLK);
    end
    MReady = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        rd, wr, rdy;
    logic [31:0] addr, wdata;
    logic        exp_stall;
    logic [3:0]  exp_we;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"ld40",   1, 0, 0, 32'h40, 32'h0,         0, 4'b0000, 1, 32'h1};
    vecs[1] = '{"st44",   0, 1, 0, 32'h44, 32'hDEADBEEF,  0, 4'b0001, 0, 32'h0};
    vecs[2] = '{"ld44",   1, 0, 0, 32'h44, 32'h0,         0, 4'b0000, 1, 32'hDEADBEEF};
    vecs[3] = '{"ld4c",   1, 0, 0, 32'h4C, 32'h0,         0, 4'b0000, 1, 32'h4};
    vecs[4] = '{"idlerdy",0, 0, 1, 32'h80, 32'h0,         0, 4'b0000, 0, 32'h0};
    vecs[5] = '{"rdwr48", 1, 1, 0, 32'h48, 32'h12345678,  0, 4'b0001, 0, 32'h0};
    vecs[6] = '{"ld48",   1, 0, 0, 32'h48, 32'h0,         0, 4'b0000, 1, 32'h12345678};

    Reset = 1'b1; MemRead = 0; MemWrite = 0; Addr = '0; WriteData = '0;
    MRD = '0; MReady = 0;
    @(negedge CLK); @(negedge CLK);
    #1;
    check("rst mreq", {31'd0, MReq}, 32'd0);
    check("rst mwe", {31'd0, MWE}, 32'd0);
    check("rst blkwe", {28'd0, BlkWE}, 32'd0);
    check("rst stall", {31'd0, Stall}, 32'd0);
    check("rst hits", HitCount, 32'd0);
    check("rst misses", MissCount, 32'd0);
    Reset = 1'b0;
    @(negedge CLK);

    // Clean miss on 0x40, refill 1..4 with 3-cycle beat spacing.
    MemRead = 1; Addr = 32'h40;
    #1 check("m1 stall", {31'd0, Stall}, 32'd1);
    check("m1 no mreq yet", {31'd0, MReq}, 32'd0);
    @(negedge CLK);
    check("m1 misses", MissCount, 32'd1);
    mem_phase("fill40", 1'b0, 32'h40, 32'h1, 32'h2, 32'h3, 32'h4, 2, 4);
    #1;
    check("m1 replay stall", {31'd0, Stall}, 32'd0);
    check("m1 replay data", ReadData, 32'h1);
    check("m1 mreq off", {31'd0, MReq}, 32'd0);
    @(negedge CLK);
    MemRead = 0;
    check("m1 hits", HitCount, 32'd1);
    check("m1 clean", {31'd0, m_dirty[0]}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      MemRead = vecs[v].rd; MemWrite = vecs[v].wr; MReady = vecs[v].rdy;
      Addr = vecs[v].addr; WriteData = vecs[v].wdata;
      #1;
      check({vecs[v].name, " stall"}, {31'd0, Stall}, {31'd0, vecs[v].exp_stall});
      check({vecs[v].name, " blkwe"}, {28'd0, BlkWE}, {28'd0, vecs[v].exp_we});
      check({vecs[v].name, " mreq"}, {31'd0, MReq}, 32'd0);
      if (vecs[v].chk_rd) check({vecs[v].name, " rdata"}, ReadData, vecs[v].exp_rdata);
      @(negedge CLK);
    end
    MemRead = 0; MemWrite = 0; MReady = 0;
    #1;
    check("tbl hits", HitCount, 32'd7);
    check("tbl misses", MissCount, 32'd1);
    check("tbl dirty", {31'd0, m_dirty[0]}, 32'd1);
    @(negedge CLK);

    // Dirty conflict miss: writeback back-to-back, then refill from 0x80.
    MemRead = 1; Addr = 32'h80;
    #1 check("m2 stall", {31'd0, Stall}, 32'd1);
    @(negedge CLK);
    check("m2 misses", MissCount, 32'd2);
    mem_phase("wb40", 1'b1, 32'h40, 32'h1, 32'hDEADBEEF, 32'h12345678, 32'h4, 0, 4);
    mem_phase("fill80", 1'b0, 32'h80, 32'hA, 32'hB, 32'hC, 32'hD, 1, 4);
    #1;
    check("m2 replay stall", {31'd0, Stall}, 32'd0);
    check("m2 replay data", ReadData, 32'hA);
    @(negedge CLK);
    MemRead = 0;
    check("m2 hits", HitCount, 32'd8);
    check("m2 clean", {31'd0, m_dirty[0]}, 32'd0);
    check("m2 tag", {6'd0, m_tag[0]}, 32'h2);

    // Reset in the middle of a refill.
    @(negedge CLK);
    MemRead = 1; Addr = 32'h90;
    @(negedge CLK);
    mem_phase("fill90a", 1'b0, 32'h90, 32'h11, 32'h22, 32'h33, 32'h44, 0, 2);
    Reset = 1'b1;
    #1;
    check("rs mreq", {31'd0, MReq}, 32'd0);
    check("rs mwe", {31'd0, MWE}, 32'd0);
    check("rs blkwe", {28'd0, BlkWE}, 32'd0);
    check("rs misses", MissCount, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("rs re-miss stall", {31'd0, Stall}, 32'd1);
    check("rs idle mreq", {31'd0, MReq}, 32'd0);
    @(negedge CLK);
    check("rs misses again", MissCount, 32'd1);
    mem_phase("fill90b", 1'b0, 32'h90, 32'h55, 32'h66, 32'h77, 32'h88, 1, 4);
    #1;
    check("rs replay data", ReadData, 32'h55);
    @(negedge CLK);
    MemRead = 0;
    check("rs hits", HitCount, 32'd1);

    // Hit counter wrap.
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.hit_cnt_q;
    #1 check("wrap preload", HitCount, 32'hFFFF_FFFF);
    MemRead = 1; Addr = 32'h9C;
    #1;
    check("wrap stall", {31'd0, Stall}, 32'd0);
    check("wrap data", ReadData, 32'h88);
    @(negedge CLK);
    MemRead = 0;
    check("wrap hits", HitCount, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
